// File: rtl/pixel_write_responder.sv
// pixel_write_responder: target side of the LCD pixel-write handshake.
// Stores accepted writes in an on-chip RGB565 framebuffer, stretches
// pixelReady to mimic LCD write latency, and offers a registered readback
// port, an in-range write counter, a saturating range-error counter and a
// one-address-per-cycle bulk clear.
module pixel_write_responder #(
  parameter int          WIDTH        = 240,
  parameter int          HEIGHT       = 320,
  parameter int          WRITE_CYCLES = 4,
  parameter logic [15:0] CLEAR_COLOUR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  input  logic        clear,
  output logic        clearBusy,
  input  logic [7:0]  rdX,
  input  logic [8:0]  rdY,
  output logic [15:0] rdData,
  output logic [31:0] pixelCount,
  output logic [15:0] rangeErrors
);

  localparam int                DEPTH     = WIDTH * HEIGHT;
  localparam int                ADDR_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        BUSY_INIT = 8'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, REARM, CLEAR} state_t;

  state_t              state_q, state_d;
  logic                pixel_ready_q, pixel_ready_d;
  logic                clear_busy_q, clear_busy_d;
  logic [31:0]         pixel_count_q, pixel_count_d;
  logic [15:0]         range_errors_q, range_errors_d;
  logic [7:0]          busy_cnt_q, busy_cnt_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic [15:0]         rd_data_q, rd_data_d;

  logic [15:0]         mem [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [15:0]         mem_wdata;

  // Linear addresses are formed at 32 bits so y*WIDTH never truncates;
  // only in-range results are used, and those fit in ADDR_W bits.
  logic [31:0] wr_lin, rd_lin;
  logic        wr_in_range, rd_in_range;
  logic        unused_hi;

  assign wr_lin      = 32'(yAddr) * 32'(WIDTH) + 32'(xAddr);
  assign rd_lin      = 32'(rdY) * 32'(WIDTH) + 32'(rdX);
  assign wr_in_range = (32'(xAddr) < 32'(WIDTH)) && (32'(yAddr) < 32'(HEIGHT));
  assign rd_in_range = (32'(rdX) < 32'(WIDTH)) && (32'(rdY) < 32'(HEIGHT));
  assign unused_hi   = ^{wr_lin[31:ADDR_W], rd_lin[31:ADDR_W]};

  // Handshake / clear sequencing and framebuffer write-port selection.
  always_comb begin
    state_d        = state_q;
    pixel_ready_d  = pixel_ready_q;
    clear_busy_d   = clear_busy_q;
    pixel_count_d  = pixel_count_q;
    range_errors_d = range_errors_q;
    busy_cnt_d     = busy_cnt_q;
    clr_addr_d     = clr_addr_q;
    mem_we         = 1'b0;
    mem_waddr      = wr_lin[ADDR_W-1:0];
    mem_wdata      = pixelData;
    case (state_q)
      REARM: begin
        // Wait for the initiator to drop its request so one request = one write.
        pixel_ready_d = 1'b1;
        if (!pixelWrite) state_d = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_d        = CLEAR;
          pixel_ready_d  = 1'b0;
          clear_busy_d   = 1'b1;
          clr_addr_d     = '0;
          pixel_count_d  = '0;
          range_errors_d = '0;
        end else if (pixelWrite) begin
          if (wr_in_range) begin
            mem_we        = 1'b1;
            pixel_count_d = pixel_count_q + 32'd1;
          end else if (range_errors_q != 16'hFFFF) begin
            range_errors_d = range_errors_q + 16'd1;
          end
          pixel_ready_d = 1'b0;
          busy_cnt_d    = BUSY_INIT;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        if (busy_cnt_q == 8'd0) begin
          pixel_ready_d = 1'b1;
          state_d       = REARM;
        end else begin
          busy_cnt_d = busy_cnt_q - 8'd1;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = CLEAR_COLOUR;
        if (clr_addr_q == LAST_ADDR) begin
          clear_busy_d  = 1'b0;
          pixel_ready_d = 1'b1;
          state_d       = REARM;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = REARM;
    endcase
  end

  // Registered readback; out-of-range coordinates read as zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_in_range) rd_data_d = mem[rd_lin[ADDR_W-1:0]];
  end

  // Control and counter registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= REARM;
      pixel_ready_q  <= 1'b0;
      clear_busy_q   <= 1'b0;
      pixel_count_q  <= '0;
      range_errors_q <= '0;
      busy_cnt_q     <= '0;
      clr_addr_q     <= '0;
      rd_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      pixel_ready_q  <= pixel_ready_d;
      clear_busy_q   <= clear_busy_d;
      pixel_count_q  <= pixel_count_d;
      range_errors_q <= range_errors_d;
      busy_cnt_q     <= busy_cnt_d;
      clr_addr_q     <= clr_addr_d;
      rd_data_q      <= rd_data_d;
    end
  end

  // Framebuffer storage; deliberately not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign pixelReady  = pixel_ready_q;
  assign clearBusy   = clear_busy_q;
  assign pixelCount  = pixel_count_q;
  assign rangeErrors = range_errors_q;
  assign rdData      = rd_data_q;

endmodule

// File: tb/tb_pixel_write_responder.sv
// Bench for pixel_write_responder: directed handshake, range, sprite,
// clear and reset scenarios, checked every cycle against a behavioural
// framebuffer model plus literal expectations.
module tb_pixel_write_responder;

  localparam int          W  = 240;
  localparam int          H  = 320;
  localparam int          WC = 4;
  localparam int          N  = W * H;
  localparam logic [15:0] CC = 16'h001F;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  xAddr = '0;
  logic [8:0]  yAddr = '0;
  logic [15:0] pixelData = '0;
  logic        pixelWrite = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  rdX = '0;
  logic [8:0]  rdY = '0;
  logic        pixelReady;
  logic        clearBusy;
  logic [15:0] rdData;
  logic [31:0] pixelCount;
  logic [15:0] rangeErrors;

  pixel_write_responder #(
    .WIDTH(W), .HEIGHT(H), .WRITE_CYCLES(WC), .CLEAR_COLOUR(CC)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .clear(clear), .clearBusy(clearBusy),
    .rdX(rdX), .rdY(rdY), .rdData(rdData),
    .pixelCount(pixelCount), .rangeErrors(rangeErrors)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] fb_m [N];
  bit          fb_k [N];
  bit          m_ready = 1'b0;
  bit          m_cbusy = 1'b0;
  logic [31:0] m_count = '0;
  logic [15:0] m_errs = '0;
  logic [15:0] m_rd = '0;
  bit          m_rd_k = 1'b1;
  bit          m_rearm = 1'b1;
  int          m_busy_left = 0;
  bit          m_clearing = 1'b0;
  int          m_clr_idx = 0;
  int          m_idx;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if (m_clearing) for (int i = 0; i < N; i++) fb_k[i] = 1'b0;
      m_ready = 0; m_cbusy = 0; m_count = '0; m_errs = '0;
      m_rd = '0; m_rd_k = 1; m_rearm = 1; m_busy_left = 0;
      m_clearing = 0; m_clr_idx = 0;
    end else begin
      if (int'(rdX) < W && int'(rdY) < H) begin
        m_idx  = int'(rdY) * W + int'(rdX);
        m_rd   = fb_m[m_idx];
        m_rd_k = fb_k[m_idx];
      end else begin
        m_rd = '0; m_rd_k = 1;
      end
      if (m_rearm) begin
        m_ready = 1;
        if (!pixelWrite) m_rearm = 0;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin m_ready = 1; m_rearm = 1; end
      end else if (m_clearing) begin
        fb_m[m_clr_idx] = CC;
        fb_k[m_clr_idx] = 1;
        m_clr_idx++;
        if (m_clr_idx == N) begin
          m_clearing = 0; m_cbusy = 0; m_ready = 1; m_rearm = 1;
        end
      end else if (clear) begin
        m_clearing = 1; m_clr_idx = 0; m_ready = 0; m_cbusy = 1;
        m_count = '0; m_errs = '0;
      end else if (pixelWrite) begin
        if (int'(xAddr) < W && int'(yAddr) < H) begin
          m_idx = int'(yAddr) * W + int'(xAddr);
          fb_m[m_idx] = pixelData;
          fb_k[m_idx] = 1;
          m_count = m_count + 1;
        end else if (m_errs != 16'hFFFF) begin
          m_errs = m_errs + 1;
        end
        m_ready = 0;
        m_busy_left = WC;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("pixelReady", {31'b0, pixelReady}, {31'b0, m_ready});
    check("clearBusy", {31'b0, clearBusy}, {31'b0, m_cbusy});
    check("pixelCount", pixelCount, m_count);
    check("rangeErrors", {16'b0, rangeErrors}, {16'b0, m_errs});
    if (m_rd_k) check("rdData", {16'b0, rdData}, {16'b0, m_rd});
  end

  // ---------------- driver tasks ----------------
  task automatic write_px(input int x, input int y, input logic [15:0] d,
                          input int hold_extra, output int low);
    bit done;
    done = 0;
    low  = 0;
    @(negedge clock);
    xAddr = 8'(x); yAddr = 9'(y); pixelData = d; pixelWrite = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clock);
      if (!pixelReady) low++;
      else if (low > 0) done = 1;
    end
    check("write_handshake_done", {31'b0, done}, 32'd1);
    repeat (1 + hold_extra) begin
      @(negedge clock);
      check("ready_while_held", {31'b0, pixelReady}, 32'd1);
    end
    pixelWrite = 1'b0;
    @(negedge clock);
  endtask

  task automatic read_px(input int x, input int y, output logic [15:0] d);
    @(negedge clock);
    rdX = 8'(x); rdY = 9'(y);
    @(negedge clock);
    d = rdData;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [15:0] d;
    int low;
    int cyc;
    repeat (2) @(negedge clock);
    check("rst_pixelReady", {31'b0, pixelReady}, 32'd0);
    check("rst_clearBusy", {31'b0, clearBusy}, 32'd0);
    check("rst_pixelCount", pixelCount, 32'd0);
    check("rst_rangeErrors", {16'b0, rangeErrors}, 32'd0);
    check("rst_rdData", {16'b0, rdData}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("ready_first_edge", {31'b0, pixelReady}, 32'd1);

    // Basic write and readback
    write_px(10, 20, 16'hF800, 0, low);
    check("low_cycles_basic", low, 32'd4);
    read_px(10, 20, d);
    check("rd_10_20", {16'b0, d}, 32'h0000F800);
    check("count_after_first", pixelCount, 32'd1);

    // Initiator holds the request well past pixelReady rising
    write_px(11, 20, 16'h07E0, 3, low);
    check("low_cycles_hold", low, 32'd4);
    check("count_after_hold", pixelCount, 32'd2);
    read_px(11, 20, d);
    check("rd_11_20", {16'b0, d}, 32'h000007E0);

    // Out-of-range writes
    write_px(240, 5, 16'hFFFF, 0, low);
    check("low_cycles_oor_x", low, 32'd4);
    write_px(3, 320, 16'h1111, 0, low);
    check("low_cycles_oor_y", low, 32'd4);
    check("range_errors_2", {16'b0, rangeErrors}, 32'd2);
    check("count_after_oor", pixelCount, 32'd2);
    read_px(240, 5, d);
    check("rd_oor_zero", {16'b0, d}, 32'd0);

    // 4x3 sprite at (100,200), columns written right-to-left
    write_px(99, 200, 16'h07E0, 0, low);
    for (int r = 0; r < 3; r++)
      for (int c = 3; c >= 0; c--)
        write_px(100 + c, 200 + r, 16'hA000 | 16'(r << 4) | 16'(c), 0, low);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) begin
        read_px(100 + c, 200 + r, d);
        check("sprite_px", {16'b0, d}, {16'b0, 16'hA000 | 16'(r << 4) | 16'(c)});
      end
    read_px(99, 200, d);
    check("sprite_neighbour", {16'b0, d}, 32'h000007E0);
    check("count_after_sprite", pixelCount, 32'd15);

    // Reset while a write is being stretched
    @(negedge clock);
    xAddr = 8'd1; yAddr = 9'd1; pixelData = 16'hBEEF; pixelWrite = 1'b1;
    @(negedge clock);
    check("busy_ready_low", {31'b0, pixelReady}, 32'd0);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rstbusy_ready", {31'b0, pixelReady}, 32'd0);
    check("rstbusy_cbusy", {31'b0, clearBusy}, 32'd0);
    check("rstbusy_count", pixelCount, 32'd0);
    check("rstbusy_errs", {16'b0, rangeErrors}, 32'd0);
    pixelWrite = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rstbusy_ready_back", {31'b0, pixelReady}, 32'd1);
    write_px(2, 2, 16'h0F0F, 0, low);
    check("rstbusy_low", low, 32'd4);
    check("rstbusy_count1", pixelCount, 32'd1);

    // Clear and write requested together
    @(negedge clock);
    clear = 1'b1; pixelWrite = 1'b1;
    xAddr = 8'd7; yAddr = 9'd9; pixelData = 16'h1234;
    @(negedge clock);
    clear = 1'b0;
    check("clear_started", {31'b0, clearBusy}, 32'd1);
    check("clear_ready_low", {31'b0, pixelReady}, 32'd0);
    check("clear_count0", pixelCount, 32'd0);
    cyc = 1;
    for (int n = 0; n < 80000; n++) begin
      @(negedge clock);
      if (clearBusy) cyc++;
      else break;
    end
    check("clear_cycles", cyc, 32'd76800);
    check("clear_ready_back", {31'b0, pixelReady}, 32'd1);
    pixelWrite = 1'b0;
    @(negedge clock);
    check("clear_write_pending", pixelCount, 32'd0);
    write_px(7, 9, 16'h1234, 0, low);
    check("post_clear_low", low, 32'd4);
    check("post_clear_count", pixelCount, 32'd1);
    for (int k = 0; k < N; k += 127) begin
      @(negedge clock);
      rdX = 8'(k % W); rdY = 9'(k / W);
    end
    read_px(0, 0, d);     check("clr_0_0", {16'b0, d}, 32'h0000001F);
    read_px(239, 319, d); check("clr_last", {16'b0, d}, 32'h0000001F);
    read_px(10, 20, d);   check("clr_10_20", {16'b0, d}, 32'h0000001F);
    read_px(99, 200, d);  check("clr_99_200", {16'b0, d}, 32'h0000001F);
    read_px(7, 9, d);     check("rd_7_9", {16'b0, d}, 32'h00001234);

    // Reset in the middle of a clear
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    repeat (50) @(negedge clock);
    check("midclear_busy", {31'b0, clearBusy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstclr_ready", {31'b0, pixelReady}, 32'd0);
    check("rstclr_cbusy", {31'b0, clearBusy}, 32'd0);
    check("rstclr_count", pixelCount, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rstclr_ready_back", {31'b0, pixelReady}, 32'd1);
    write_px(5, 5, 16'hCAFE, 0, low);
    check("rstclr_low", low, 32'd4);
    check("rstclr_count1", pixelCount, 32'd1);
    read_px(5, 5, d);
    check("rd_5_5", {16'b0, d}, 32'h0000CAFE);

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
